updown_sweep_ctrl: RTL and testbench

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

---
 rtl/updown_sweep_ctrl_pkg.sv | 14 +
 rtl/updown_sweep_ctrl_if.sv | 32 +++
 rtl/updown_sweep_ctrl_sweep_cnt4.sv | 33 +++
 rtl/updown_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the up/down triangle sweep controller.
package updown_sweep_ctrl_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_PASS_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DONE = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Control/status bundle of the sweep controller; master drives commands, slave is the controller.
interface updown_sweep_ctrl_if
   import updown_sweep_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PASS_W = DEF_PASS_W
);

   logic              start;
   logic              abort;
   logic              pause;
   logic [WIDTH-1:0]  lo;
   logic [WIDTH-1:0]  hi;
   logic [PASS_W-1:0] passes;
   logic [WIDTH-1:0]  q;
   logic              dir;
   logic              busy;
   logic              done;
   logic              err;
   logic [PASS_W-1:0] pass_cnt;

   modport master (
      output start, abort, pause, lo, hi, passes,
      input  q, dir, busy, done, err, pass_cnt
   );

   modport slave (
      input  start, abort, pause, lo, hi, passes,
      output q, dir, busy, done, err, pass_cnt
   );

endinterface

// File: rtl/updown_sweep_ctrl_sweep_cnt4.sv
// Loadable up/down count register; callers guarantee it never steps past its bounds.
module sweep_cnt4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;

   // Count register: load has priority over stepping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_r <= {WIDTH{1'b0}};
      end else if (load) begin
         q_r <= load_val;
      end else if (en) begin
         q_r <= up ? (q_r + ONE) : (q_r - ONE);
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep controller: counts lo..hi..lo for a programmed number of passes.
module updown_sweep_ctrl
   import updown_sweep_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PASS_W = DEF_PASS_W
) (
   input logic                clk,
   input logic                rst,
   updown_sweep_ctrl_if.slave bus
);

   localparam logic [PASS_W-1:0] PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};
   localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};

   sweep_state_e      state_r, state_nx_s;
   logic              dir_r, dir_nx_s;
   logic              err_r, err_nx_s;
   logic [PASS_W-1:0] pass_cnt_r, pass_nx_s, pass_inc_s;
   logic [WIDTH-1:0]  lo_r, lo_nx_s;
   logic [WIDTH-1:0]  hi_r, hi_nx_s;
   logic [PASS_W-1:0] passes_r, passes_nx_s;
   logic              load_s, en_s, up_s;
   logic [WIDTH-1:0]  q_s;

   sweep_cnt4 #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .load_val (bus.lo),
      .en       (en_s),
      .up       (up_s),
      .q        (q_s)
   );

   assign pass_inc_s = pass_cnt_r + PASS_ONE;

   // State and control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         dir_r      <= 1'b1;
         err_r      <= 1'b0;
         pass_cnt_r <= PASS_ZERO;
         lo_r       <= {WIDTH{1'b0}};
         hi_r       <= {WIDTH{1'b0}};
         passes_r   <= PASS_ZERO;
      end else begin
         state_r    <= state_nx_s;
         dir_r      <= dir_nx_s;
         err_r      <= err_nx_s;
         pass_cnt_r <= pass_nx_s;
         lo_r       <= lo_nx_s;
         hi_r       <= hi_nx_s;
         passes_r   <= passes_nx_s;
      end
   end

   // Next-state and counter control; abort overrides pause, pause overrides counting.
   always_comb begin
      state_nx_s  = state_r;
      dir_nx_s    = dir_r;
      err_nx_s    = 1'b0;
      pass_nx_s   = pass_cnt_r;
      lo_nx_s     = lo_r;
      hi_nx_s     = hi_r;
      passes_nx_s = passes_r;
      load_s      = 1'b0;
      en_s        = 1'b0;
      up_s        = 1'b1;

      if (bus.abort) begin
         state_nx_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if ((bus.lo <= bus.hi) && (bus.passes != PASS_ZERO)) begin
                     lo_nx_s     = bus.lo;
                     hi_nx_s     = bus.hi;
                     passes_nx_s = bus.passes;
                     load_s      = 1'b1;
                     dir_nx_s    = 1'b1;
                     pass_nx_s   = PASS_ZERO;
                     state_nx_s  = UP;
                  end else begin
                     err_nx_s = 1'b1;
                  end
               end else begin
                  state_nx_s = IDLE;
               end
            end
            UP: begin
               if (bus.pause) begin
                  state_nx_s = UP;
               end else if (lo_r == hi_r) begin
                  // Degenerate sweep: every cycle in UP completes a pass.
                  pass_nx_s  = pass_inc_s;
                  state_nx_s = (pass_inc_s == passes_r) ? DONE : UP;
               end else if (q_s < hi_r) begin
                  en_s = 1'b1;
               end else begin
                  en_s       = 1'b1;
                  up_s       = 1'b0;
                  dir_nx_s   = 1'b0;
                  state_nx_s = DOWN;
               end
            end
            DOWN: begin
               if (bus.pause) begin
                  state_nx_s = DOWN;
               end else if (q_s > lo_r) begin
                  en_s = 1'b1;
                  up_s = 1'b0;
               end else begin
                  pass_nx_s = pass_inc_s;
                  if (pass_inc_s == passes_r) begin
                     state_nx_s = DONE;
                  end else begin
                     // lo is shared with the next pass, so resume at lo+1.
                     state_nx_s = UP;
                     dir_nx_s   = 1'b1;
                     en_s       = 1'b1;
                  end
               end
            end
            DONE: begin
               state_nx_s = IDLE;
            end
            default: begin
               state_nx_s = IDLE;
            end
         endcase
      end
   end

   assign bus.q        = q_s;
   assign bus.dir      = dir_r;
   assign bus.busy     = (state_r == UP) || (state_r == DOWN);
   assign bus.done     = (state_r == DONE);
   assign bus.err      = err_r;
   assign bus.pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomized and directed bench for updown_sweep_ctrl against a sequence-list reference model.
module tb_updown_sweep_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   model_q;

   updown_sweep_ctrl_if #(.WIDTH(4), .PASS_W(4)) bus ();

   updown_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Idle-state check: expected q, done, pass count; busy and err always 0 here.
   task automatic check_idle(input string name, input int eq, input bit edone, input int epc);
      logic [3:0] q4;
      logic [3:0] p4;
      q4 = eq[3:0];
      p4 = epc[3:0];
      total++;
      if ({bus.q, bus.busy, bus.done, bus.err, bus.pass_cnt} !== {q4, 1'b0, edone, 1'b0, p4}) begin
         bad++;
         $display("FAIL %s: got q=%0d busy=%b done=%b err=%b pc=%0d want q=%0d busy=0 done=%b err=0 pc=%0d",
                  name, bus.q, bus.busy, bus.done, bus.err, bus.pass_cnt, q4, edone, p4);
      end
   endtask

   // One sweep: expected q list is [lo] + passes x (lo+1..hi, hi-1..lo), or passes x [lo] when lo==hi.
   task automatic sweep(input int lo, input int hi, input int np, input bit rand_pause,
                        input bit noise, input int pause_idx, input int pause_len, input int abort_idx);
      int q_list[$];
      int d, idx, held, guard, k, epc_i;
      bit p, edir;
      logic [3:0] eq, epc;
      d = hi - lo;
      if (d == 0) begin
         for (int i = 0; i < np; i++) q_list.push_back(lo);
      end else begin
         q_list.push_back(lo);
         for (int i = 0; i < np; i++) begin
            for (int v = lo + 1; v <= hi; v++) q_list.push_back(v);
            for (int v = hi - 1; v >= lo; v--) q_list.push_back(v);
         end
      end
      bus.lo = lo[3:0]; bus.hi = hi[3:0]; bus.passes = np[3:0]; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idx = 0; held = 0; guard = 0;
      while (idx < q_list.size() && guard < 4000) begin
         guard++;
         if (d == 0) begin
            epc_i = idx; edir = 1'b1;
         end else if (idx == 0) begin
            epc_i = 0; edir = 1'b1;
         end else begin
            k = (idx - 1) % (2 * d);
            epc_i = (idx - 1) / (2 * d);
            edir = (k < d);
         end
         eq = q_list[idx][3:0];
         epc = epc_i[3:0];
         total++;
         if ({bus.q, bus.dir, bus.busy, bus.done, bus.err, bus.pass_cnt} !== {eq, edir, 1'b1, 1'b0, 1'b0, epc}) begin
            bad++;
            $display("FAIL sweep[%0d..%0d x%0d] idx %0d: got q=%0d dir=%b busy=%b done=%b err=%b pc=%0d want q=%0d dir=%b busy=1 done=0 err=0 pc=%0d",
                     lo, hi, np, idx, bus.q, bus.dir, bus.busy, bus.done, bus.err, bus.pass_cnt, eq, edir, epc);
         end
         if (idx == abort_idx) begin
            bus.pause = 1'b0; bus.start = 1'b0; bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            check_idle("abort_next", q_list[idx], 1'b0, epc_i);
            @(posedge clk); #1;
            check_idle("abort_no_done", q_list[idx], 1'b0, epc_i);
            model_q = q_list[idx];
            return;
         end
         p = 1'b0;
         if (idx == pause_idx && held < pause_len) begin
            p = 1'b1; held++;
         end else if (rand_pause && $urandom_range(0, 3) == 0) begin
            p = 1'b1;
         end
         bus.pause = p;
         if (noise && $urandom_range(0, 2) == 0) begin
            bus.start = 1'b1; bus.lo = 4'($urandom); bus.hi = 4'($urandom); bus.passes = 4'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         if (!p) idx++;
      end
      bus.start = 1'b0; bus.pause = 1'b0;
      total++;
      if (guard >= 4000) begin
         bad++;
         $display("FAIL sweep_budget: got %0d cycles want < 4000", guard);
      end
      check_idle("done_pulse", lo, 1'b1, np);
      @(posedge clk); #1;
      check_idle("after_done", lo, 1'b0, np);
      model_q = lo;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
      bus.lo = 4'd0; bus.hi = 4'd0; bus.passes = 4'd0;
      #12;
      check_idle("reset", 0, 1'b0, 0);
      total++;
      if (bus.dir !== 1'b1) begin
         bad++;
         $display("FAIL reset_dir: got %b want 1", bus.dir);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle("reset_release", 0, 1'b0, 0);
      model_q = 0;
   endtask

   task automatic test_directed();
      sweep(2, 5, 1, 1'b0, 1'b0, -1, 0, -1);
      sweep(0, 15, 2, 1'b0, 1'b0, -1, 0, -1);
      sweep(7, 7, 3, 1'b0, 1'b0, -1, 0, -1);
   endtask

   task automatic test_err();
      bus.lo = 4'd6; bus.hi = 4'd3; bus.passes = 4'd1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++;
      if ({bus.err, bus.busy, bus.q} !== {1'b1, 1'b0, 4'(model_q)}) begin
         bad++;
         $display("FAIL err_lo_gt_hi: got err=%b busy=%b q=%0d want err=1 busy=0 q=%0d", bus.err, bus.busy, bus.q, model_q);
      end
      @(posedge clk); #1;
      total++;
      if (bus.err !== 1'b0) begin
         bad++;
         $display("FAIL err_one_cycle: got err=%b want 0", bus.err);
      end
      bus.lo = 4'd2; bus.hi = 4'd5; bus.passes = 4'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++;
      if ({bus.err, bus.busy, bus.q} !== {1'b1, 1'b0, 4'(model_q)}) begin
         bad++;
         $display("FAIL err_zero_passes: got err=%b busy=%b q=%0d want err=1 busy=0 q=%0d", bus.err, bus.busy, bus.q, model_q);
      end
      @(posedge clk); #1;
      check_idle("err_cleared", model_q, 1'b0, 3);
   endtask

   task automatic test_pause_abort();
      sweep(1, 4, 1, 1'b0, 1'b0, 2, 3, 5);
   endtask

   task automatic test_reset_mid();
      bus.lo = 4'd1; bus.hi = 4'd6; bus.passes = 4'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      total++;
      if ({bus.q, bus.busy} !== {4'd4, 1'b1}) begin
         bad++;
         $display("FAIL reset_mid_pre: got q=%0d busy=%b want q=4 busy=1", bus.q, bus.busy);
      end
      #2 rst = 1'b0;
      #1;
      check_idle("reset_mid_async", 0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_idle("reset_mid_wait", 0, 1'b0, 0);
      end
      model_q = 0;
   endtask

   task automatic test_random();
      int lo, hi, np;
      for (int n = 0; n < 10; n++) begin
         lo = $urandom_range(0, 15);
         hi = $urandom_range(lo, 15);
         np = $urandom_range(1, 3);
         sweep(lo, hi, np, 1'b1, 1'b1, -1, 0, -1);
      end
   endtask

   task automatic test_back_to_back();
      sweep(0, 1, 2, 1'b0, 1'b0, -1, 0, -1);
      sweep(15, 15, 1, 1'b0, 1'b0, -1, 0, -1);
      sweep(14, 15, 1, 1'b0, 1'b1, -1, 0, -1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_directed();
      test_err();
      test_pause_abort();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
